inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Instruction-fetch front end, directly upstream of the core control unit.
- Accepts the control unit's fetch request (stb/cyc in FETCH state) and runs a single read cycle on the instruction-memory bus at the current PC.
- Latches the returned word into the instruction register (IR) and returns the one-cycle inst_ack the control unit needs to enter DECODE.
- Splits IR into the op/func fields the control unit decodes; a bus timeout substitutes NOP_INSTR and flags an error.

Parameters:
ADDR_W, 12, width of PC and instruction bus address
INST_W, 18, instruction width
TIMEOUT, 16, max bus cycles waiting for memory ack before error (>=2)
NOP_INSTR, 18'h00000, word loaded into IR on reset and on timeout

Ports:
clk  input  1  clock
rst  input  1  reset
cu_stb_i  input  1  fetch strobe from control unit
cu_cyc_i  input  1  fetch cycle from control unit
pc_i  input  ADDR_W  current program counter
inst_ack_o  output  1  one-cycle pulse: IR updated, control unit may decode
inst_adr_o  output  ADDR_W  instruction bus address
inst_cyc_o  output  1  instruction bus cycle
inst_stb_o  output  1  instruction bus strobe
inst_dat_i  input  INST_W  instruction bus read data
inst_ack_i  input  1  instruction bus acknowledge
ir_o  output  INST_W  instruction register
op_o  output  7  ir_o[INST_W-1:INST_W-7], combinational from IR
func_o  output  3  ir_o[2:0], combinational from IR
bus_err_o  output  1  sticky timeout flag

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high.
- Reset values:
  - state IDLE; ir_o = NOP_INSTR.
  - inst_adr_o, inst_cyc_o, inst_stb_o, inst_ack_o, bus_err_o = 0; timeout counter = 0.
- All outputs except op_o/func_o are registered.
- States: IDLE, BUS, DONE, ERR.
- IDLE:
  - If cu_stb_i & cu_cyc_i: register inst_adr_o <= pc_i, inst_cyc_o = inst_stb_o <= 1, counter <= 0, go BUS.
  - inst_ack_i is ignored in IDLE.
- BUS:
  - Bus signals stay high; inst_adr_o is held constant (later pc_i changes are ignored).
  - inst_ack_i = 1: IR <= inst_dat_i, drop cyc/stb, go DONE.
  - Otherwise, if counter == TIMEOUT-1: IR <= NOP_INSTR, drop cyc/stb, go ERR.
  - Otherwise counter increments.
  - cu_cyc_i = 0 (abort): drop cyc/stb, go IDLE, IR unchanged, no inst_ack_o.
  - Abort has priority over ack and timeout in the same cycle.
- DONE: inst_ack_o = 1 for exactly this cycle; go IDLE.
- ERR: inst_ack_o = 1 for this cycle, bus_err_o <= 1; go IDLE.
- bus_err_o stays high until rst.
- A new request is accepted only in IDLE. Holding cu_stb_i/cu_cyc_i high through DONE causes a new fetch to start in the cycle after DONE.
- Latency: request sampled at edge 0; bus asserted after edge 0. Memory ack sampled at edge k gives IR and inst_ack_o valid after edge k+1. With zero-wait memory (ack at edge 1), inst_ack_o is high after edge 2.
- rst mid-BUS: bus drops next edge; no ack pulse; IR = NOP_INSTR.
- Counter width: clog2(TIMEOUT); it never wraps because the ERR transition precedes overflow.

Test Plan:
- Reset, then idle with inst_ack_i = 1 held → no bus cycle, inst_ack_o = 0, ir_o = 0x00000, bus_err_o = 0.
- pc_i = 0x02A, request held; memory acks on first bus cycle with dat = 0x3F805 → inst_adr_o = 0x02A; inst_ack_o pulses once, 2 cycles after request; ir_o = 0x3F805; op_o = 0x7F; func_o = 5.
- Memory waits 5 cycles then acks with 0x12345, pc_i changed to 0x100 during the wait → inst_adr_o stays 0x02A; ir_o = 0x12345; single inst_ack_o pulse.
- No ack for 16 bus cycles → cyc/stb drop; ir_o = NOP_INSTR; inst_ack_o pulses once; bus_err_o = 1 and stays 1 through a following successful fetch.
- cu_cyc_i drops in BUS in the same cycle inst_ack_i = 1 → abort wins: no inst_ack_o, ir_o keeps its previous value, state IDLE.
- rst asserted mid-BUS → next cycle all bus outputs = 0, ir_o = NOP_INSTR, no ack; the next request fetches normally.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end sitting directly upstream of the core control unit.
//
// The control unit's fetch request (cu_stb_i & cu_cyc_i) starts one read cycle
// on the instruction bus at pc_i. The returned word is latched into the
// instruction register (IR) and a one-cycle inst_ack_o lets the control unit
// move on to decode. If memory never acknowledges within TIMEOUT bus cycles,
// NOP_INSTR is loaded instead and the sticky bus_err_o flag is raised.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cu_stb_i, cu_cyc_i  fetch request from the control unit (cu_cyc_i low aborts)
//   pc_i                current program counter, sampled when a fetch starts
//   inst_ack_o          one-cycle pulse: IR updated, control unit may decode
//   inst_adr_o          instruction bus address (held for the whole bus cycle)
//   inst_cyc_o          instruction bus cycle
//   inst_stb_o          instruction bus strobe
//   inst_dat_i          instruction bus read data
//   inst_ack_i          instruction bus acknowledge
//   ir_o                instruction register
//   op_o, func_o        opcode / function fields decoded from IR
//   bus_err_o           sticky timeout flag, cleared only by rst
module inst_fetch_unit #(
    parameter int unsigned      ADDR_W    = 12,
    parameter int unsigned      INST_W    = 18,
    parameter int unsigned      TIMEOUT   = 16,
    parameter logic [INST_W-1:0] NOP_INSTR = 18'h00000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cu_stb_i,
    input  logic              cu_cyc_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              inst_ack_o,
    output logic [ADDR_W-1:0] inst_adr_o,
    output logic              inst_cyc_o,
    output logic              inst_stb_o,
    input  logic [INST_W-1:0] inst_dat_i,
    input  logic              inst_ack_i,
    output logic [INST_W-1:0] ir_o,
    output logic [6:0]        op_o,
    output logic [2:0]        func_o,
    output logic              bus_err_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    // Last wait cycle; ERR is taken here so the counter never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic              bus_q, bus_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [INST_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        bus_d   = bus_q;
        ack_d   = 1'b0;
        err_d   = err_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (cu_stb_i && cu_cyc_i) begin
                    adr_d   = pc_i;
                    bus_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StBus;
                end
            end
            StBus: begin
                // Abort outranks a same-cycle ack or timeout: IR is left untouched.
                if (!cu_cyc_i) begin
                    bus_d   = 1'b0;
                    state_d = StIdle;
                end else if (inst_ack_i) begin
                    ir_d    = inst_dat_i;
                    bus_d   = 1'b0;
                    state_d = StDone;
                end else if (cnt_q == CNT_LAST) begin
                    ir_d    = NOP_INSTR;
                    bus_d   = 1'b0;
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                ack_d   = 1'b1;
                state_d = StIdle;
            end
            StErr: begin
                ack_d   = 1'b1;
                err_d   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            adr_q   <= '0;
            bus_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            ir_q    <= NOP_INSTR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            bus_q   <= bus_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    assign inst_adr_o = adr_q;
    assign inst_cyc_o = bus_q;
    assign inst_stb_o = bus_q;
    assign inst_ack_o = ack_q;
    assign bus_err_o  = err_q;
    assign ir_o       = ir_q;
    assign op_o       = ir_q[INST_W-1 -: 7];
    assign func_o     = ir_q[2:0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus randomized fetches, all
// checked cycle by cycle against a transaction-level model of the fetch timing.
module tb_inst_fetch_unit;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned INST_W  = 18;
    localparam int unsigned TIMEOUT = 16;
    localparam logic [INST_W-1:0] NOP = 18'h00000;

    logic              clk = 1'b0;
    logic              rst;
    logic              cu_stb_i;
    logic              cu_cyc_i;
    logic [ADDR_W-1:0] pc_i;
    logic              inst_ack_o;
    logic [ADDR_W-1:0] inst_adr_o;
    logic              inst_cyc_o;
    logic              inst_stb_o;
    logic [INST_W-1:0] inst_dat_i;
    logic              inst_ack_i;
    logic [INST_W-1:0] ir_o;
    logic [6:0]        op_o;
    logic [2:0]        func_o;
    logic              bus_err_o;

    inst_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .TIMEOUT  (TIMEOUT),
        .NOP_INSTR(NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cu_stb_i  (cu_stb_i),
        .cu_cyc_i  (cu_cyc_i),
        .pc_i      (pc_i),
        .inst_ack_o(inst_ack_o),
        .inst_adr_o(inst_adr_o),
        .inst_cyc_o(inst_cyc_o),
        .inst_stb_o(inst_stb_o),
        .inst_dat_i(inst_dat_i),
        .inst_ack_i(inst_ack_i),
        .ir_o      (ir_o),
        .op_o      (op_o),
        .func_o    (func_o),
        .bus_err_o (bus_err_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: what IR and the error flag should hold.
    logic [INST_W-1:0] ir_model;
    logic              err_model;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete fetch. Memory acks on bus cycle w (edge w after the request
    // edge 0); w > TIMEOUT means memory never answers. The fetch ends at edge
    // last = min(w, TIMEOUT): bus high after edges 0..last-1, IR updated after
    // edge last, inst_ack_o high only after edge last+1.
    task automatic run_fetch(input string tag, input logic [ADDR_W-1:0] pc,
                             input logic [INST_W-1:0] dat, input int w,
                             input bit change_pc, input logic [ADDR_W-1:0] new_pc,
                             input bit hold_after);
        int  last;
        bit  ok;
        bit  exp_bus;
        logic [INST_W-1:0] ir_new;
        ok     = (w <= int'(TIMEOUT));
        last   = ok ? w : int'(TIMEOUT);
        ir_new = ok ? dat : NOP;
        cu_stb_i = 1'b1;
        cu_cyc_i = 1'b1;
        pc_i     = pc;
        for (int n = 0; n <= last + 1; n++) begin
            inst_ack_i = (n == w);
            inst_dat_i = (n == w) ? dat : INST_W'($urandom);
            step();
            if (n == last) ir_model = ir_new;
            if (n == last + 1 && !ok) err_model = 1'b1;
            exp_bus = (n < last);
            checks++;
            if (inst_cyc_o !== exp_bus || inst_stb_o !== exp_bus) begin
                errors++;
                $display("FAIL %s bus n=%0d: got cyc=%b stb=%b want %b", tag, n,
                         inst_cyc_o, inst_stb_o, exp_bus);
            end
            checks++;
            if (inst_ack_o !== (n == last + 1)) begin
                errors++;
                $display("FAIL %s inst_ack n=%0d: got %b want %b", tag, n, inst_ack_o,
                         (n == last + 1));
            end
            if (exp_bus) begin
                checks++;
                if (inst_adr_o !== pc) begin
                    errors++;
                    $display("FAIL %s adr n=%0d: got %h want %h", tag, n, inst_adr_o, pc);
                end
            end
            checks++;
            if (ir_o !== ir_model) begin
                errors++;
                $display("FAIL %s ir n=%0d: got %h want %h", tag, n, ir_o, ir_model);
            end
            checks++;
            if (op_o !== 7'((ir_model >> (INST_W - 7)) & 18'h7f) ||
                func_o !== 3'(ir_model & 18'h7)) begin
                errors++;
                $display("FAIL %s fields n=%0d: got op=%h func=%h for ir %h", tag, n, op_o,
                         func_o, ir_model);
            end
            checks++;
            if (bus_err_o !== err_model) begin
                errors++;
                $display("FAIL %s bus_err n=%0d: got %b want %b", tag, n, bus_err_o,
                         err_model);
            end
            if (n == 0 && change_pc) pc_i = new_pc;
        end
        inst_ack_i = 1'b0;
        if (!hold_after) begin
            cu_stb_i = 1'b0;
            cu_cyc_i = 1'b0;
        end
        // Edge after the ack pulse: no second pulse; a held request restarts here.
        step();
        checks++;
        if (inst_ack_o !== 1'b0 || inst_cyc_o !== hold_after) begin
            errors++;
            $display("FAIL %s tail: got ack=%b cyc=%b want ack=0 cyc=%b", tag, inst_ack_o,
                     inst_cyc_o, hold_after);
        end
        if (hold_after) begin
            checks++;
            if (inst_adr_o !== pc_i) begin
                errors++;
                $display("FAIL %s restart adr: got %h want %h", tag, inst_adr_o, pc_i);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cu_stb_i = 1'b0;
        cu_cyc_i = 1'b0;
        pc_i = '0;
        inst_dat_i = '0;
        inst_ack_i = 1'b0;
        step();
        step();
        ir_model  = NOP;
        err_model = 1'b0;
        checks++;
        if (inst_cyc_o !== 1'b0 || inst_stb_o !== 1'b0 || inst_ack_o !== 1'b0 ||
            inst_adr_o !== '0 || ir_o !== NOP || bus_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset values: got cyc=%b stb=%b ack=%b adr=%h ir=%h err=%b",
                     inst_cyc_o, inst_stb_o, inst_ack_o, inst_adr_o, ir_o, bus_err_o);
        end
        rst = 1'b0;
        inst_ack_i = 1'b1;
        inst_dat_i = 18'h2aaaa;
        for (int n = 0; n < 4; n++) begin
            step();
            checks++;
            if (inst_cyc_o !== 1'b0 || inst_ack_o !== 1'b0 || ir_o !== NOP ||
                bus_err_o !== 1'b0) begin
                errors++;
                $display("FAIL idle_ack n=%0d: got cyc=%b ack=%b ir=%h err=%b want 0 0 0 0",
                         n, inst_cyc_o, inst_ack_o, ir_o, bus_err_o);
            end
        end
        inst_ack_i = 1'b0;
    endtask

    task automatic test_zero_wait();
        run_fetch("zero_wait", 12'h02a, 18'h3f805, 1, 1'b0, '0, 1'b0);
        checks++;
        if (op_o !== 7'h7f || func_o !== 3'd5) begin
            errors++;
            $display("FAIL zero_wait decode: got op=%h func=%0d want 7f 5", op_o, func_o);
        end
    endtask

    task automatic test_wait_states();
        run_fetch("wait5", 12'h02a, 18'h12345, 6, 1'b1, 12'h100, 1'b0);
        // Ack on the very last allowed bus cycle still counts as success.
        run_fetch("ack_at_limit", 12'h7f3, 18'h0abcd, int'(TIMEOUT), 1'b0, '0, 1'b0);
    endtask

    task automatic test_timeout();
        run_fetch("timeout", 12'h055, 18'h1ffff, int'(TIMEOUT) + 4, 1'b0, '0, 1'b0);
        run_fetch("after_timeout", 12'h056, 18'h22222, 2, 1'b0, '0, 1'b0);
    endtask

    task automatic test_abort();
        cu_stb_i = 1'b1;
        cu_cyc_i = 1'b1;
        pc_i = 12'h3c3;
        for (int n = 0; n < 3; n++) begin
            inst_ack_i = 1'b0;
            step();
            checks++;
            if (inst_cyc_o !== 1'b1 || inst_ack_o !== 1'b0) begin
                errors++;
                $display("FAIL abort_wait n=%0d: got cyc=%b ack=%b want 1 0", n, inst_cyc_o,
                         inst_ack_o);
            end
        end
        cu_stb_i = 1'b0;
        cu_cyc_i = 1'b0;
        inst_ack_i = 1'b1;
        inst_dat_i = ~ir_model;
        step();
        inst_ack_i = 1'b0;
        checks++;
        if (inst_cyc_o !== 1'b0 || inst_stb_o !== 1'b0 || inst_ack_o !== 1'b0 ||
            ir_o !== ir_model) begin
            errors++;
            $display("FAIL abort: got cyc=%b stb=%b ack=%b ir=%h want 0 0 0 %h", inst_cyc_o,
                     inst_stb_o, inst_ack_o, ir_o, ir_model);
        end
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (inst_ack_o !== 1'b0 || ir_o !== ir_model) begin
                errors++;
                $display("FAIL abort_after n=%0d: got ack=%b ir=%h want 0 %h", n, inst_ack_o,
                         ir_o, ir_model);
            end
        end
        run_fetch("after_abort", 12'h3c4, 18'h15a5a, 3, 1'b0, '0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_fetch("b2b_first", 12'h111, 18'h0f0f0, 2, 1'b1, 12'h222, 1'b1);
        cu_stb_i = 1'b0;
        cu_cyc_i = 1'b0;
        step();
        checks++;
        if (inst_cyc_o !== 1'b0 || inst_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_abort: got cyc=%b ack=%b want 0 0", inst_cyc_o, inst_ack_o);
        end
    endtask

    task automatic test_reset_mid_bus();
        cu_stb_i = 1'b1;
        cu_cyc_i = 1'b1;
        pc_i = 12'h5a5;
        inst_ack_i = 1'b0;
        for (int n = 0; n < 3; n++) step();
        rst = 1'b1;
        inst_ack_i = 1'b1;
        inst_dat_i = 18'h33333;
        step();
        ir_model  = NOP;
        err_model = 1'b0;
        checks++;
        if (inst_cyc_o !== 1'b0 || inst_stb_o !== 1'b0 || inst_adr_o !== '0 ||
            inst_ack_o !== 1'b0 || ir_o !== NOP || bus_err_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_bus: got cyc=%b stb=%b adr=%h ack=%b ir=%h err=%b",
                     inst_cyc_o, inst_stb_o, inst_adr_o, inst_ack_o, ir_o, bus_err_o);
        end
        rst = 1'b0;
        inst_ack_i = 1'b0;
        cu_stb_i = 1'b0;
        cu_cyc_i = 1'b0;
        step();
        checks++;
        if (inst_ack_o !== 1'b0 || inst_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: got ack=%b cyc=%b want 0 0", inst_ack_o, inst_cyc_o);
        end
        run_fetch("after_rst", 12'h5a6, 18'h2468a, 4, 1'b0, '0, 1'b0);
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] dat;
        int w;
        for (int i = 0; i < 24; i++) begin
            pc  = ADDR_W'($urandom);
            dat = INST_W'($urandom);
            if ($urandom_range(0, 4) == 0) w = int'($urandom_range(TIMEOUT + 2, TIMEOUT + 6));
            else w = int'($urandom_range(1, TIMEOUT));
            run_fetch("random", pc, dat, w, 1'($urandom), ADDR_W'($urandom), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_reset_mid_bus();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
